// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the board-input conditioner.
package input_conditioner_pkg;

    localparam int unsigned CLK_FREQ_HZ         = 50_000_000;
    localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchroniser, stability counter, stable level and
// registered rise/fall pulses aligned with the level change.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS_DEFAULT),
    parameter bit          INVERT          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    typedef logic [CNT_W-1:0] db_cnt_t;
    localparam db_cnt_t CNT_LAST = db_cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam logic    PIN_IDLE = INVERT;

    logic    r_meta;
    logic    r_sync;
    logic    r_stable;
    logic    r_rise;
    logic    r_fall;
    db_cnt_t r_cnt;

    logic    w_sync;
    logic    w_mismatch;
    logic    w_commit;

    assign w_sync     = r_sync ^ INVERT;
    assign w_mismatch = (w_sync != r_stable);
    assign w_commit   = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: synchroniser flops reset to the pin's idle level so leaving reset never looks like a press.
            r_meta   <= PIN_IDLE;
            r_sync   <= PIN_IDLE;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_rise <= w_commit &  w_sync;
            r_fall <= w_commit & ~w_sync;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_commit) begin
                r_cnt    <= '0;
                r_stable <= w_sync;
            end else begin
                r_cnt <= r_cnt + db_cnt_t'(1);
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces DE-10 switches and keys; key auto-repeat is
// enabled by defining INPUT_CONDITIONER_KEY_REPEAT_EN.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned NUM_SW          = 10,
    parameter int unsigned NUM_KEY         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS_DEFAULT)
`ifdef INPUT_CONDITIONER_KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SW-1:0]  sw_raw_i,
    input  logic [NUM_KEY-1:0] key_raw_ni,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_KEY-1:0] key_pressed_o,
    output logic [NUM_KEY-1:0] key_pulse_o,
    output logic [NUM_KEY-1:0] key_release_pulse_o
);

    logic [NUM_SW-1:0]  w_sw_rise;
    logic [NUM_SW-1:0]  w_sw_fall;
    logic [NUM_KEY-1:0] w_key_press;
    logic               w_unused_sw_edges;

    // Switch edges are not exported; only their levels matter downstream.
    assign w_unused_sw_edges = ^{w_sw_rise, w_sw_fall};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (1'b0)
        ) u_db (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .i_raw  (sw_raw_i[g]),
            .o_level(sw_o[g]),
            .o_rise (w_sw_rise[g]),
            .o_fall (w_sw_fall[g])
        );
    end

    for (genvar g = 0; g < NUM_KEY; g++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (1'b1)
        ) u_db (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .i_raw  (key_raw_ni[g]),
            .o_level(key_pressed_o[g]),
            .o_rise (w_key_press[g]),
            .o_fall (key_release_pulse_o[g])
        );
    end

`ifdef INPUT_CONDITIONER_KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    typedef logic [REP_W-1:0] rep_cnt_t;
    localparam rep_cnt_t DELAY_LAST  = rep_cnt_t'(REPEAT_DELAY - 1);
    localparam rep_cnt_t PERIOD_LAST = rep_cnt_t'(REPEAT_PERIOD - 1);

    logic [NUM_KEY-1:0] w_rep_pulse;

    for (genvar g = 0; g < NUM_KEY; g++) begin : g_repeat
        rep_cnt_t r_rep_cnt;
        logic     r_in_period;
        logic     r_rep_pulse;
        logic     w_fire;

        assign w_fire = (r_rep_cnt == (r_in_period ? PERIOD_LAST : DELAY_LAST));

        always_ff @(posedge clk_i) begin
            if (rst_i || !key_pressed_o[g]) begin
                r_rep_cnt   <= '0;
                r_in_period <= 1'b0;
                r_rep_pulse <= 1'b0;
            end else if (w_fire) begin
                r_rep_cnt   <= '0;
                r_in_period <= 1'b1;
                r_rep_pulse <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + rep_cnt_t'(1);
                r_rep_pulse <= 1'b0;
            end
        end

        // Gating with the live level stops a repeat landing on the release cycle.
        assign w_rep_pulse[g] = r_rep_pulse & key_pressed_o[g];
    end

    assign key_pulse_o = w_key_press | w_rep_pulse;
`else
    assign key_pulse_o = w_key_press;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4; the repeat
// sequence expectations follow INPUT_CONDITIONER_KEY_REPEAT_EN.
module tb_input_conditioner;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sw_raw = '0;
    logic [3:0] key_raw = 4'hF;
    logic [9:0] sw_o;
    logic [3:0] key_pressed;
    logic [3:0] key_pulse;
    logic [3:0] key_rel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .NUM_SW         (10),
        .NUM_KEY        (4),
        .DEBOUNCE_CYCLES(DB)
`ifdef INPUT_CONDITIONER_KEY_REPEAT_EN
        ,
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
`endif
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .sw_raw_i           (sw_raw),
        .key_raw_ni         (key_raw),
        .sw_o               (sw_o),
        .key_pressed_o      (key_pressed),
        .key_pulse_o        (key_pulse),
        .key_release_pulse_o(key_rel)
    );

    typedef struct {
        logic [9:0]  sw;
        logic [3:0]  key;
        int unsigned wait_n;
        logic [9:0]  exp_sw;
        logic [3:0]  exp_pressed;
        logic [3:0]  exp_pulse;
        logic [3:0]  exp_rel;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string name, input logic [9:0] e_sw, input logic [3:0] e_pr,
                             input logic [3:0] e_pu, input logic [3:0] e_rel);
        check({name, ".sw"},      32'(sw_o),        32'(e_sw));
        check({name, ".pressed"}, 32'(key_pressed), 32'(e_pr));
        check({name, ".pulse"},   32'(key_pulse),   32'(e_pu));
        check({name, ".release"}, 32'(key_rel),     32'(e_rel));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] bounce;
        logic       exp_pulse0;

        vecs[0] = '{10'h000, 4'hF, 5, 10'h3FF, 4'h0, 4'h0, 4'h0, "sw_fall_wait5"};
        vecs[1] = '{10'h000, 4'hF, 1, 10'h000, 4'h0, 4'h0, 4'h0, "sw_fall_cycle6"};
        vecs[2] = '{10'h000, 4'hE, 5, 10'h000, 4'h0, 4'h0, 4'h0, "key0_press_wait5"};
        vecs[3] = '{10'h000, 4'hE, 1, 10'h000, 4'h1, 4'h1, 4'h0, "key0_press_cycle6"};
        vecs[4] = '{10'h000, 4'hE, 1, 10'h000, 4'h1, 4'h0, 4'h0, "key0_press_cycle7"};
        vecs[5] = '{10'h000, 4'hF, 6, 10'h000, 4'h0, 4'h0, 4'h1, "key0_release"};
        vecs[6] = '{10'h000, 4'hF, 1, 10'h000, 4'h0, 4'h0, 4'h0, "key0_release_after"};
        vecs[7] = '{10'h2A5, 4'hF, 6, 10'h2A5, 4'h0, 4'h0, 4'h0, "sw_pattern"};

        // Reset held with all switches up and keys released.
        rst = 1'b1; sw_raw = 10'h3FF; key_raw = 4'hF;
        tick(3);
        check_all("in_reset", 10'h000, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick(1);
            check_all($sformatf("post_reset_c%0d", c), (c < 6) ? 10'h000 : 10'h3FF, 4'h0, 4'h0, 4'h0);
        end

        for (int i = 0; i < 8; i++) begin
            sw_raw  = vecs[i].sw;
            key_raw = vecs[i].key;
            tick(vecs[i].wait_n);
            check_all(vecs[i].name, vecs[i].exp_sw, vecs[i].exp_pressed, vecs[i].exp_pulse, vecs[i].exp_rel);
        end

        // SW[3] bounce: only the final run of ones is long enough.
        bounce = 9'b1_1110_1110;
        for (int i = 0; i < 9; i++) begin
            sw_raw[3] = bounce[i];
            tick(1);
            check($sformatf("bounce_c%0d", i + 1), 32'(sw_o), 32'h2A5);
        end
        tick(1);
        check("bounce_c10", 32'(sw_o), 32'h2A5);
        tick(1);
        check("bounce_c11", 32'(sw_o), 32'h2AD);

        // KEY[1] and KEY[2] together, KEY[1] released ten cycles later.
        key_raw = 4'b1001;
        tick(5);
        check_all("dual_c5", 10'h2AD, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("dual_c6", 10'h2AD, 4'b0110, 4'b0110, 4'h0);
        for (int c = 7; c <= 10; c++) begin
            tick(1);
            check($sformatf("dual_pulse_c%0d", c), 32'(key_pulse), 32'h0);
        end
        key_raw = 4'b1011;
        tick(5);
        check_all("dual_rel_c15", 10'h2AD, 4'b0110, 4'h0, 4'h0);
        tick(1);
        check_all("dual_rel_c16", 10'h2AD, 4'b0100, 4'h0, 4'b0010);
        key_raw = 4'hF;
        tick(6);
        check_all("dual_rel_key2", 10'h2AD, 4'h0, 4'h0, 4'b0100);

        // KEY[3] held while a one-cycle reset lands mid-count.
        key_raw = 4'b0111;
        for (int c = 1; c <= 4; c++) begin
            tick(1);
            check($sformatf("rstmid_pulse_c%0d", c), 32'(key_pulse), 32'h0);
        end
        rst = 1'b1;
        tick(1);
        check_all("rstmid_in_reset", 10'h000, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick(1);
            check($sformatf("rstmid_wait_c%0d", c), 32'(key_pulse), 32'h0);
        end
        tick(1);
        check_all("rstmid_c6", 10'h2AD, 4'h8, 4'h8, 4'h0);
        tick(1);
        check("rstmid_c7_pulse", 32'(key_pulse), 32'h0);
        key_raw = 4'hF;
        tick(6);
        check_all("key3_release", 10'h2AD, 4'h0, 4'h0, 4'h8);

        // KEY[0] held for 20 cycles at the pin; repeats only when enabled.
        key_raw = 4'hE;
        for (int c = 1; c <= 32; c++) begin
            tick(1);
`ifdef INPUT_CONDITIONER_KEY_REPEAT_EN
            exp_pulse0 = (c == 6) || (c == 14) || (c == 17) || (c == 20) || (c == 23);
`else
            exp_pulse0 = (c == 6);
`endif
            check($sformatf("hold_pulse_c%0d", c), 32'(key_pulse), 32'(exp_pulse0));
            check($sformatf("hold_rel_c%0d", c), 32'(key_rel), (c == 26) ? 32'h1 : 32'h0);
            if (c == 20) key_raw = 4'hF;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
